// File: rtl/tail_light_pkg.sv
// Shared tail-light definitions: light-state encoding and counter widths.
// The output-logic decoder uses these same codes, so keep the two in step.
package tail_light_pkg;

    localparam int STATE_W = 3;
    localparam int CNT_W   = 2;

    // Code 3'b111 is deliberately left unassigned.
    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'b000,
        LEFT   = 3'b001,
        RIGHT  = 3'b010,
        LBREAK = 3'b011,
        RBREAK = 3'b100,
        BREAK  = 3'b101,
        HAZARD = 3'b110
    } state_e;

endpackage

// File: rtl/tail_light_ctrl_tick.sv
// Blink-rate prescaler: one-cycle tick every TICK_DIV clocks; clr restarts the period.
module blink_tick_gen #(
    parameter int TICK_DIV = 12500000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + PW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tail_light_ctrl.sv
// Tail-light sequencer: synchronises the four switches, holds the light state and
// runs the sweep/blink counters that the output logic decodes.
module tail_light_ctrl
    import tail_light_pkg::*;
#(
    parameter int TICK_DIV    = 12500000,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sw_left,
    input  logic               sw_right,
    input  logic               sw_brake,
    input  logic               sw_hazard,
    output logic [STATE_W-1:0] current_state,
    output logic [CNT_W-1:0]   count_lb,
    output logic [CNT_W-1:0]   count_rb,
    output logic               count_h
);

    // Switch vector layout: {hazard, brake, right, left}.
    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic [SYNC_STAGES-1:0][3:0] sync_d;
    logic                        l_s, r_s, b_s, h_s;

    state_e                      state_q, state_d;
    logic [CNT_W-1:0]            lb_q, lb_d;
    logic [CNT_W-1:0]            rb_q, rb_d;
    logic                        h_q, h_d;
    logic                        state_chg;
    logic                        tick;

    always_comb begin
        sync_d[0] = {sw_hazard, sw_brake, sw_right, sw_left};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign {h_s, b_s, r_s, l_s} = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = IDLE;
        if (state_q == state_e'(3'b111)) begin
            state_d = IDLE;
        end else if (h_s) begin
            state_d = HAZARD;
        end else if (b_s && l_s && !r_s) begin
            state_d = LBREAK;
        end else if (b_s && r_s && !l_s) begin
            state_d = RBREAK;
        end else if (b_s) begin
            state_d = BREAK;
        end else if (l_s && !r_s) begin
            state_d = LEFT;
        end else if (r_s && !l_s) begin
            state_d = RIGHT;
        end
    end

    assign state_chg = (state_d != state_q);

    blink_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (state_chg),
        .tick  (tick)
    );

    // A state change always restarts the sweep, even on a tick edge.
    always_comb begin
        lb_d = lb_q;
        rb_d = rb_q;
        h_d  = h_q;
        if (state_chg || !(state_q == LEFT || state_q == LBREAK)) begin
            lb_d = '0;
        end else if (tick) begin
            lb_d = lb_q + CNT_W'(1);
        end
        if (state_chg || !(state_q == RIGHT || state_q == RBREAK)) begin
            rb_d = '0;
        end else if (tick) begin
            rb_d = rb_q + CNT_W'(1);
        end
        if (state_chg || state_q != HAZARD) begin
            h_d = 1'b0;
        end else if (tick) begin
            h_d = !h_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            state_q <= IDLE;
            lb_q    <= '0;
            rb_q    <= '0;
            h_q     <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            lb_q    <= lb_d;
            rb_q    <= rb_d;
            h_q     <= h_d;
        end
    end

    assign current_state = state_q;
    assign count_lb      = lb_q;
    assign count_rb      = rb_q;
    assign count_h       = h_q;

endmodule

// File: tb/tb_tail_light_ctrl.sv
// Bench for tail_light_ctrl with TICK_DIV=4: directed scenarios plus random switch
// traffic, all checked against a behavioural model of state and time-in-state.
module tb_tail_light_ctrl;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sw_left = 1'b0, sw_right = 1'b0, sw_brake = 1'b0, sw_hazard = 1'b0;
    logic [2:0] current_state;
    logic [1:0] count_lb, count_rb;
    logic       count_h;

    int total = 0;
    int bad   = 0;

    tail_light_ctrl #(.TICK_DIV(TD), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .sw_left       (sw_left),
        .sw_right      (sw_right),
        .sw_brake      (sw_brake),
        .sw_hazard     (sw_hazard),
        .current_state (current_state),
        .count_lb      (count_lb),
        .count_rb      (count_rb),
        .count_h       (count_h)
    );

    always #5 clk = ~clk;

    // Reference: light state follows the switches three edges late; counters are
    // simply (edges spent in the current state / TD), wrapped.
    logic [3:0] seen1 = '0, seen2 = '0;
    logic [2:0] m_state = '0;
    int         m_age = 0;

    function automatic logic [2:0] ref_decode(input logic [3:0] s);
        logic l, r, b, h;
        {h, b, r, l} = s;
        if (h) return 3'd6;
        if (b) return (l && !r) ? 3'd3 : (r && !l) ? 3'd4 : 3'd5;
        if (l ^ r) return l ? 3'd1 : 3'd2;
        return 3'd0;
    endfunction

    always @(posedge clk or posedge reset) begin
        logic [2:0] nxt;
        if (reset) begin
            seen1 = '0; seen2 = '0; m_state = '0; m_age = 0;
        end else begin
            nxt = ref_decode(seen2);
            m_age = (nxt != m_state) ? 0 : m_age + 1;
            m_state = nxt;
            seen2 = seen1;
            seen1 = {sw_hazard, sw_brake, sw_right, sw_left};
        end
    end

    function automatic logic [7:0] exp_vec();
        logic [1:0] lb, rb;
        logic       h;
        int         steps;
        steps = m_age / TD;
        lb = (m_state == 3'd1 || m_state == 3'd3) ? 2'(steps % 4) : 2'd0;
        rb = (m_state == 3'd2 || m_state == 3'd4) ? 2'(steps % 4) : 2'd0;
        h  = (m_state == 3'd6) ? 1'(steps % 2) : 1'b0;
        return {m_state, lb, rb, h};
    endfunction

    function automatic logic [7:0] dut_vec();
        return {current_state, count_lb, count_rb, count_h};
    endfunction

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sw(input logic l, input logic r, input logic b, input logic h);
        @(negedge clk);
        sw_left = l; sw_right = r; sw_brake = b; sw_hazard = h;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        set_sw(1, 0, 0, 0);
        repeat (9) edge_wait();
        #2 reset = 1'b1;
        #1;
        total++;
        if (dut_vec() !== 8'h00) begin
            bad++;
            $display("FAIL reset_async got=%h exp=00", dut_vec());
        end
        sw_left = 1'b0;
        @(negedge clk) reset = 1'b0;
        for (int e = 0; e < 8; e++) begin
            edge_wait();
            total++;
            if (dut_vec() !== 8'h00) begin
                bad++;
                $display("FAIL reset_idle edge=%0d got=%h exp=00", e, dut_vec());
            end
        end
    endtask

    task automatic test_left_sweep();
        logic [1:0] want_lb;
        set_sw(1, 0, 0, 0);
        for (int e = 0; e <= 18; e++) begin
            edge_wait();
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL left_model edge=%0d got=%h exp=%h", e, dut_vec(), exp_vec());
            end
            if (e == 2) begin
                total++;
                if (current_state !== 3'b001) begin
                    bad++;
                    $display("FAIL left_entry got=%0d exp=1", current_state);
                end
            end
            if (e >= 6 && (e - 6) % 4 == 0) begin
                want_lb = 2'(((e - 2) / 4) % 4);
                total++;
                if (count_lb !== want_lb || count_rb !== 2'd0) begin
                    bad++;
                    $display("FAIL left_step edge=%0d lb=%0d rb=%0d exp_lb=%0d exp_rb=0",
                             e, count_lb, count_rb, want_lb);
                end
            end
        end
    endtask

    task automatic test_brake_during_left();
        int waited = 0;
        while (count_lb !== 2'd2 && waited < 20) begin
            edge_wait();
            waited++;
        end
        total++;
        if (count_lb !== 2'd2) begin
            bad++;
            $display("FAIL brake_wait_lb2 got=%0d exp=2", count_lb);
        end
        set_sw(1, 0, 1, 0);
        repeat (3) edge_wait();
        total++;
        if (current_state !== 3'b011 || count_lb !== 2'd0) begin
            bad++;
            $display("FAIL brake_entry state=%0d lb=%0d exp state=3 lb=0", current_state, count_lb);
        end
        repeat (4) edge_wait();
        total++;
        if (count_lb !== 2'd1 || dut_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL brake_step lb=%0d exp=1 vec=%h model=%h", count_lb, dut_vec(), exp_vec());
        end
    endtask

    task automatic test_priority();
        set_sw(1, 0, 1, 1);
        repeat (3) edge_wait();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (current_state !== 3'b110 || count_h !== 1'(k % 2)) begin
                bad++;
                $display("FAIL hazard_phase k=%0d state=%0d h=%0d exp state=6 h=%0d",
                         k, current_state, count_h, k % 2);
            end
            if (k < 3) repeat (4) edge_wait();
        end
        set_sw(1, 0, 1, 0);
        repeat (3) edge_wait();
        total++;
        if (current_state !== 3'b011) begin
            bad++;
            $display("FAIL hazard_drop got=%0d exp=3", current_state);
        end
        set_sw(0, 0, 1, 0);
        repeat (3) edge_wait();
        total++;
        if (dut_vec() !== {3'b101, 5'b0}) begin
            bad++;
            $display("FAIL left_drop got=%h exp=%h", dut_vec(), {3'b101, 5'b0});
        end
    endtask

    task automatic test_both_turns();
        set_sw(1, 1, 0, 0);
        repeat (3) edge_wait();
        total++;
        if (dut_vec() !== 8'h00) begin
            bad++;
            $display("FAIL both_turns got=%h exp=00", dut_vec());
        end
        set_sw(1, 1, 1, 0);
        repeat (3) edge_wait();
        total++;
        if (current_state !== 3'b101) begin
            bad++;
            $display("FAIL both_brake got=%0d exp=5", current_state);
        end
    endtask

    task automatic test_glitch();
        logic [2:0] want [4] = '{3'd0, 3'd0, 3'd2, 3'd0};
        set_sw(0, 0, 0, 0);
        repeat (6) edge_wait();
        set_sw(0, 1, 0, 0);
        for (int e = 0; e < 4; e++) begin
            edge_wait();
            if (e == 0) sw_right = 1'b0;
            total++;
            if (current_state !== want[e] || {count_lb, count_rb, count_h} !== 5'b0) begin
                bad++;
                $display("FAIL glitch edge=%0d state=%0d cnt=%b exp state=%0d cnt=00000",
                         e, current_state, {count_lb, count_rb, count_h}, want[e]);
            end
        end
        repeat (6) edge_wait();
        total++;
        if (dut_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL glitch_after got=%h exp=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        int hold;
        for (int seg = 0; seg < 40; seg++) begin
            set_sw(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 4) == 0));
            hold = $urandom_range(1, 20);
            for (int c = 0; c < hold; c++) begin
                edge_wait();
                total++;
                if (dut_vec() !== exp_vec()) begin
                    bad++;
                    $display("FAIL random seg=%0d cyc=%0d got=%h exp=%h", seg, c, dut_vec(), exp_vec());
                end
            end
            if (seg == 20) begin
                #2 reset = 1'b1;
                #1;
                total++;
                if (dut_vec() !== 8'h00) begin
                    bad++;
                    $display("FAIL random_reset got=%h exp=00", dut_vec());
                end
                @(negedge clk) reset = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_left_sweep();
        test_brake_during_left();
        test_priority();
        test_both_turns();
        test_glitch();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
